data_sink_fifo: RTL and testbench

DATA_SINK_FIFO -- requirements
Module: data_sink_fifo

---
 rtl/data_sink_fifo_pkg.sv | 5 +
 rtl/data_sink_fifo_ram.sv | 18 +
 rtl/data_sink_fifo.sv | 64 ++++++
 tb/tb_data_sink_fifo.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/data_sink_fifo_pkg.sv
// minitb: shared bus width and default sink FIFO depth
package minitb;
   localparam int BusWidth      = 8;
   localparam int DataFifoDepth = 8;
endpackage

// File: rtl/data_sink_fifo_ram.sv
// data_fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset
module data_fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   // write port; contents are deliberately left unreset
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/data_sink_fifo.sv
// data_sink_fifo: first-word fall-through FIFO for a bus without backpressure, counting dropped words
module data_sink_fifo
   import minitb::*;
#(
   parameter int WIDTH = BusWidth,
   parameter int DEPTH = DataFifoDepth
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic [7:0]                   drop_cnt,
   input  logic                         clr_overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic        overflow_q, overflow_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;
   logic        empty, full, push, pop, drop;
   // pointers carry an extra wrap bit so full and empty are distinguishable; a drop overrides a same-cycle clear
   always_comb begin
      empty      = wptr_q == rptr_q;
      full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      pop        = !empty && out_ready;
      push       = in_valid && (!full || pop);
      drop       = in_valid && !push;
      wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
      overflow_d = drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
      drop_cnt_d = drop ? (clr_overflow ? 8'd1 : drop_cnt_q + {7'd0, drop_cnt_q != 8'hFF})
                        : (clr_overflow ? 8'd0 : drop_cnt_q);
      out_valid  = !empty;
      count      = CW'(wptr_q - rptr_q);
      overflow   = overflow_q;
      drop_cnt   = drop_cnt_q;
   end
   // pointer and overflow state, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   data_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (in_data),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (out_data)
   );
endmodule

// File: tb/tb_data_sink_fifo.sv
// tb_data_sink_fifo: vector table plus directed multi-cycle sequences for data_sink_fifo
module tb_data_sink_fifo;
   import minitb::*;
   localparam int W = BusWidth;
   localparam int D = DataFifoDepth;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_overflow = 1'b0;
   logic [W-1:0] in_data = '0;
   logic out_valid, overflow;
   logic [W-1:0] out_data;
   logic [$clog2(D+1)-1:0] count;
   logic [7:0] drop_cnt;
   int n_cmp = 0, n_err = 0;

   data_sink_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic iv; logic [7:0] d; logic rdy; logic clr;
      logic ev; logic chkd; logic [7:0] ed; logic [3:0] ec; logic eo; logic [7:0] edc;
   } vec_t;
   vec_t v[$];

   function automatic vec_t mk(logic iv, logic [7:0] d, logic rdy, logic clr, logic ev,
                               logic chkd, logic [7:0] ed, logic [3:0] ec, logic eo, logic [7:0] edc);
      vec_t r;
      r.iv = iv; r.d = d; r.rdy = rdy; r.clr = clr; r.ev = ev;
      r.chkd = chkd; r.ed = ed; r.ec = ec; r.eo = eo; r.edc = edc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
      in_valid = iv; in_data = d; out_ready = rdy; clr_overflow = clr;
      @(posedge clk); #1;
   endtask

   logic [7:0] q[$];
   logic [7:0] exp8 [8];
   int issued, npop;

   initial begin
      v.push_back(mk(1, 8'hA5, 0, 0, 1, 1, 8'hA5, 1, 0, 0));
      v.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'hA5, 1, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));
      v.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));
      for (int k = 1; k <= 8; k++) v.push_back(mk(1, 8'(k), 0, 0, 1, 1, 8'h01, 4'(k), 0, 0));
      v.push_back(mk(1, 8'h99, 0, 0, 1, 1, 8'h01, 8, 1, 1));
      for (int k = 1; k <= 8; k++) v.push_back(mk(0, 8'h00, 1, 0, k < 8, k < 8, 8'(k + 1), 4'(8 - k), 1, 1));
      v.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0));

      #12;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_count", count, 0);
      chk("reset_overflow", overflow, 0);
      chk("reset_drop_cnt", drop_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < v.size(); i++) begin
         step(v[i].iv, v[i].d, v[i].rdy, v[i].clr);
         chk($sformatf("vec%0d_out_valid", i), out_valid, v[i].ev);
         if (v[i].chkd) chk($sformatf("vec%0d_out_data", i), out_data, v[i].ed);
         chk($sformatf("vec%0d_count", i), count, v[i].ec);
         chk($sformatf("vec%0d_overflow", i), overflow, v[i].eo);
         chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, v[i].edc);
      end

      for (int k = 0; k < 8; k++) step(1, 8'(8'h20 + k), 0, 0);
      chk("full_count", count, 8);
      step(1, 8'h10, 1, 0);
      chk("fullpp_count", count, 8);
      chk("fullpp_overflow", overflow, 0);
      chk("fullpp_head", out_data, 8'h21);
      for (int k = 0; k < 7; k++) exp8[k] = 8'(8'h21 + k);
      exp8[7] = 8'h10;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("fullpp_drain%0d", k), out_data, exp8[k]);
         step(0, 8'h00, 1, 0);
      end
      chk("fullpp_empty", count, 0);

      issued = 0; npop = 0;
      for (int i = 0; i < 1000 && (issued < 100 || q.size() > 0); i++) begin
         logic iv, rdy;
         logic [7:0] d;
         iv = issued < 100 && (i % 4) < 2;
         rdy = i[0];
         d = 8'((issued * 37 + 11) & 8'hFF);
         if (rdy && q.size() > 0) begin
            chk("wrap_valid", out_valid, 1);
            chk("wrap_data", out_data, q.pop_front());
            npop++;
         end
         if (iv) begin
            q.push_back(d);
            issued++;
         end
         step(iv, d, rdy, 0);
      end
      chk("wrap_pops", npop, 100);
      chk("wrap_overflow", overflow, 0);
      chk("wrap_count", count, 0);

      for (int k = 0; k < 8; k++) step(1, 8'(8'h40 + k), 0, 0);
      for (int k = 0; k < 300; k++) step(1, 8'hEE, 0, 0);
      chk("sat_drop_cnt", drop_cnt, 255);
      chk("sat_overflow", overflow, 1);
      chk("sat_count", count, 8);
      step(0, 8'h00, 0, 1);
      chk("clr_overflow", overflow, 0);
      chk("clr_drop_cnt", drop_cnt, 0);
      step(1, 8'hEE, 0, 1);
      chk("clrdrop_overflow", overflow, 1);
      chk("clrdrop_drop_cnt", drop_cnt, 1);
      chk("clrdrop_head", out_data, 8'h40);
      chk("clrdrop_count", count, 8);

      in_valid = 0; out_ready = 0; clr_overflow = 0;
      rst_n = 1'b0;
      #3;
      chk("rst1_count", count, 0);
      chk("rst1_overflow", overflow, 0);
      chk("rst1_drop_cnt", drop_cnt, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) step(1, 8'(8'h50 + k), 0, 0);
      chk("mid_count", count, 5);
      chk("mid_head", out_data, 8'h50);
      in_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_count", count, 0);
      #1 rst_n = 1'b1;
      step(1, 8'h3C, 0, 0);
      chk("post_out_valid", out_valid, 1);
      chk("post_out_data", out_data, 8'h3C);
      chk("post_count", count, 1);
      step(0, 8'h00, 1, 0);
      chk("post_drain", count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
